// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C SCL timing generator.
// Holds the bus-rate and SCL-phase enumerations, the FSM state encoding
// and the quarter-period divisor calculation used at elaboration.
package i2c_pkg;

  // Bus rate selection as carried on rate_sel.
  typedef enum logic [1:0] {
    RATE_10K  = 2'b00,
    RATE_100K = 2'b01,
    RATE_400K = 2'b10,
    RATE_1M   = 2'b11
  } rate_e;

  // Quarter of the SCL period: two low quarters followed by two high quarters.
  typedef enum logic [1:0] {
    PH_LOW0  = 2'd0,
    PH_LOW1  = 2'd1,
    PH_HIGH0 = 2'd2,
    PH_HIGH1 = 2'd3
  } phase_e;

  // FSM state encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_Q0   = 3'd1;
  localparam state_t ST_Q1   = 3'd2;
  localparam state_t ST_Q2   = 3'd3;
  localparam state_t ST_Q3   = 3'd4;

  // Quarter-period length in system clocks, truncated: clk_hz / (4 * rate).
  function automatic int unsigned quarter_div(input int unsigned clk_hz, input rate_e rate);
    case (rate)
      RATE_10K:  return clk_hz / 40_000;
      RATE_100K: return clk_hz / 400_000;
      RATE_400K: return clk_hz / 1_600_000;
      default:   return clk_hz / 4_000_000;
    endcase
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchroniser for the raw SCL pad input.
// Resets to 1 so a released bus reads as released straight out of reset.
module i2c_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the pad level through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/i2c_scl_gen.sv
// SCL timing generator for the I2C master.
// Splits each SCL period into four equal quarters of div cycles and emits
// single-cycle phase/drive/sample strobes plus the registered SCL drive level.
// Optional macro STRETCH_EN: synchronises scl_i and holds the first high
// quarter until the bus actually reads high (slave clock stretching).
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] rate_sel,
  input  logic       scl_i,
  output logic       scl_o,
  output logic [1:0] phase,
  output logic       phase_stb,
  output logic       drive_stb,
  output logic       sample_stb,
  output logic       busy
);

  localparam int unsigned DIV_10K  = quarter_div(CLK_FREQ_HZ, RATE_10K);
  localparam int unsigned DIV_100K = quarter_div(CLK_FREQ_HZ, RATE_100K);
  localparam int unsigned DIV_400K = quarter_div(CLK_FREQ_HZ, RATE_400K);
  localparam int unsigned DIV_1M   = quarter_div(CLK_FREQ_HZ, RATE_1M);
  // The 10 kHz divisor is the largest; div-1 always fits in $clog2(div) bits.
  localparam int CNT_W = $clog2(DIV_10K);

  if (DIV_10K < 2 || DIV_100K < 2 || DIV_400K < 2 || DIV_1M < 2) begin : g_div_check
    $error("i2c_scl_gen: CLK_FREQ_HZ too low, a quarter-period divisor is below 2");
  end

  // Terminal count (div - 1) for the selected rate.
  function automatic logic [CNT_W-1:0] div_m1(input logic [1:0] sel);
    case (sel)
      2'b00:   return CNT_W'(DIV_10K - 1);
      2'b01:   return CNT_W'(DIV_100K - 1);
      2'b10:   return CNT_W'(DIV_400K - 1);
      default: return CNT_W'(DIV_1M - 1);
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             scl_q, scl_d;
  logic [1:0]       phase_q, phase_d;
  logic             phase_stb_q, phase_stb_d;
  logic             drive_stb_q, drive_stb_d;
  logic             sample_stb_q, sample_stb_d;
  logic             busy_q, busy_d;
  logic             stretch_hold;

`ifdef STRETCH_EN
  logic scl_sync;

  i2c_sync2 u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (scl_i),
    .q_o   (scl_sync)
  );

  // A slave holding SCL low keeps the first high quarter from starting to count.
  assign stretch_hold = (state_q == ST_Q2) && !scl_sync;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign stretch_hold = 1'b0;
`endif

  // Next-state and registered-output decode for the quarter sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    scl_d        = scl_q;
    phase_d      = phase_q;
    busy_d       = busy_q;
    phase_stb_d  = 1'b0;
    drive_stb_d  = 1'b0;
    sample_stb_d = 1'b0;

    if (state_q == ST_IDLE) begin
      scl_d   = 1'b1;
      phase_d = PH_LOW0;
      busy_d  = 1'b0;
      if (enable) begin
        div_d       = div_m1(rate_sel);
        state_d     = ST_Q0;
        cnt_d       = '0;
        scl_d       = 1'b0;
        phase_stb_d = 1'b1;
        busy_d      = 1'b1;
      end
    end else if (stretch_hold) begin
      cnt_d = '0;
    end else if (cnt_q != div_q) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d       = '0;
      phase_stb_d = 1'b1;
      case (state_q)
        ST_Q0: begin
          state_d     = ST_Q1;
          phase_d     = PH_LOW1;
          drive_stb_d = 1'b1;
        end
        ST_Q1: begin
          state_d = ST_Q2;
          phase_d = PH_HIGH0;
          scl_d   = 1'b1;
        end
        ST_Q2: begin
          state_d      = ST_Q3;
          phase_d      = PH_HIGH1;
          sample_stb_d = 1'b1;
        end
        default: begin
          phase_d = PH_LOW0;
          if (enable) begin
            // Period boundary: the only point where a new rate is picked up.
            state_d = ST_Q0;
            div_d   = div_m1(rate_sel);
            scl_d   = 1'b0;
          end else begin
            state_d     = ST_IDLE;
            scl_d       = 1'b1;
            busy_d      = 1'b0;
            phase_stb_d = 1'b0;
          end
        end
      endcase
    end
  end

  // State and output registers; reset releases SCL immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      div_q        <= CNT_W'(DIV_10K - 1);
      scl_q        <= 1'b1;
      phase_q      <= PH_LOW0;
      phase_stb_q  <= 1'b0;
      drive_stb_q  <= 1'b0;
      sample_stb_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      scl_q        <= scl_d;
      phase_q      <= phase_d;
      phase_stb_q  <= phase_stb_d;
      drive_stb_q  <= drive_stb_d;
      sample_stb_q <= sample_stb_d;
      busy_q       <= busy_d;
    end
  end

  assign scl_o      = scl_q;
  assign phase      = phase_q;
  assign phase_stb  = phase_stb_q;
  assign drive_stb  = drive_stb_q;
  assign sample_stb = sample_stb_q;
  assign busy       = busy_q;

endmodule
